// File: rtl/fc_batch_sequencer.sv
// fc_batch_sequencer: streams packed BRAM inputs into an FC core and writes its result vectors back, batch by batch
module fc_batch_sequencer #(
  parameter int DIM_INPUT = 96,
  parameter int DIM_OUTPUT = 8,
  parameter int INPUT_W = 16,
  parameter int OUTPUT_W = 8,
  parameter int SLOT_W = 16,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] LOAD_BASE = ADDR_W'('h000),
  parameter logic [ADDR_W-1:0] STORE_BASE = ADDR_W'('hD00),
  parameter int MAX_BATCH = 64,
  parameter int TIMEOUT_CYC = 4096,
  localparam int BN_W = $clog2(MAX_BATCH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [BN_W-1:0]                batch_num,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     err,
  output logic [BN_W-1:0]                batch_cnt,
  output logic                           fc_in_vld,
  output logic [INPUT_W-1:0]             fc_in_dat,
  input  logic                           fc_out_vld,
  input  logic [DIM_OUTPUT*OUTPUT_W-1:0] fc_out_dat,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [WORD_W-1:0]              mem_din,
  input  logic [WORD_W-1:0]              mem_dout
);
  localparam int IPW = WORD_W / INPUT_W;
  localparam int OPW = WORD_W / SLOT_W;
  localparam int NW = (DIM_OUTPUT + OPW - 1) / OPW;
  localparam int NRD = DIM_INPUT / IPW;
  localparam int CW = $clog2(DIM_INPUT + 1);
  localparam int LW = IPW > 1 ? $clog2(IPW) : 1;
  localparam int MW = NW > 1 ? $clog2(NW) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_OUT, STORE, DONE} state_t;

  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lane, olane;
  logic [ADDR_W-1:0] wcnt, rd_ptr, wr_ptr;
  logic [MW-1:0] m;
  logic [TW-1:0] tmr;
  logic [BN_W-1:0] bn;
  logic [WORD_W-1:0] word_q, src;
  logic [DIM_OUTPUT*OUTPUT_W-1:0] res;
  logic [NW*WORD_W-1:0] store_vec;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  // result vector laid out as zero-extended slots; unused slots stay 0
  always_comb begin
    store_vec = '0;
    for (int j = 0; j < DIM_OUTPUT; j++) store_vec[j*SLOT_W +: OUTPUT_W] = res[j*OUTPUT_W +: OUTPUT_W];
  end

  // next state and all outputs; lane 0 comes straight from the BRAM, later lanes from the held word
  always_comb begin
    nxt = state;
    busy = state != IDLE;
    done = state == DONE;
    fc_in_vld = state == LOAD && cnt != '0;
    src = olane == '0 ? mem_dout : word_q;
    fc_in_dat = fc_in_vld ? src[olane*INPUT_W +: INPUT_W] : '0;
    mem_en = (state == LOAD && lane == '0 && cnt != CW'(DIM_INPUT)) || state == STORE;
    mem_we = state == STORE;
    mem_addr = mem_en ? (state == STORE ? wr_ptr + ADDR_W'(m) : rd_ptr + wcnt) : '0;
    mem_din = state == STORE ? store_vec[m*WORD_W +: WORD_W] : '0;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE:     if (start) nxt = batch_num == '0 ? DONE : LOAD;
        LOAD:     if (cnt == CW'(DIM_INPUT)) nxt = WAIT_OUT;
        WAIT_OUT: nxt = fc_out_vld ? STORE : tmr == TW'(TIMEOUT_CYC - 1) ? DONE : WAIT_OUT;
        STORE:    if (m == MW'(NW - 1)) nxt = batch_cnt + 1'b1 == bn ? DONE : LOAD;
        default:  nxt = IDLE;
      endcase
  end

  // counters, pointers, captured data and sticky status
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      lane <= '0;
      olane <= '0;
      wcnt <= '0;
      m <= '0;
      tmr <= '0;
      bn <= '0;
      word_q <= '0;
      res <= '0;
      err <= '0;
      batch_cnt <= '0;
      rd_ptr <= LOAD_BASE;
      wr_ptr <= STORE_BASE;
    end else begin
      cnt <= state == LOAD && nxt == LOAD ? cnt + 1'b1 : '0;
      lane <= state == LOAD && nxt == LOAD && lane != LW'(IPW - 1) ? lane + 1'b1 : '0;
      olane <= lane;
      wcnt <= state == LOAD && nxt == LOAD ? wcnt + ADDR_W'(mem_en) : '0;
      m <= state == STORE && nxt == STORE ? m + 1'b1 : '0;
      tmr <= state == WAIT_OUT && nxt == WAIT_OUT ? tmr + 1'b1 : '0;
      if (fc_in_vld && olane == '0) word_q <= mem_dout;
      if (!abort) begin
        if (state == IDLE && start) begin
          err <= '0;
          batch_cnt <= '0;
          bn <= batch_num;
          rd_ptr <= LOAD_BASE;
          wr_ptr <= STORE_BASE;
        end
        if (state == LOAD && cnt == CW'(DIM_INPUT)) rd_ptr <= rd_ptr + ADDR_W'(NRD);
        if (state == WAIT_OUT && fc_out_vld) res <= fc_out_dat;
        if (state == WAIT_OUT && !fc_out_vld && tmr == TW'(TIMEOUT_CYC - 1)) err[0] <= 1'b1;
        if (state != WAIT_OUT && fc_out_vld) err[1] <= 1'b1;
        if (state == STORE && m == MW'(NW - 1)) begin
          wr_ptr <= wr_ptr + ADDR_W'(NW);
          batch_cnt <= batch_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_fc_batch_sequencer.sv
// tb_fc_batch_sequencer: scoreboard bench for the FC batch sequencer with a BRAM model and a responding core model
module tb_fc_batch_sequencer;
  localparam int DI = 96;
  localparam int DO = 8;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [6:0] batch_num, batch_cnt;
  logic busy, done, fc_in_vld, fc_out_vld, mem_en, mem_we;
  logic [1:0] err;
  logic [15:0] fc_in_dat;
  logic [DO*8-1:0] fc_out_dat;
  logic [11:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic start5, fc_out_vld5;
  logic [6:0] bn5, bc5;
  logic busy5, done5, in_vld5, en5, we5;
  logic [1:0] err5;
  logic [15:0] in_dat5;
  logic [39:0] fc_out_dat5;
  logic [11:0] addr5;
  logic [31:0] din5, dout5;

  logic [31:0] mem [0:4095];
  logic [31:0] mem5 [0:4095];
  logic [15:0] in_q[$];
  logic [11:0] rd_q[$];
  logic [43:0] wr_q[$];
  logic [6:0] bc_seen[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_in = 0, last_rd = 0, rd_k = 0, n_done = 0;
  bit resp_en = 1'b1, glitch = 1'b0;

  always #5 clk = ~clk;

  fc_batch_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .batch_num(batch_num), .abort(abort),
    .busy(busy), .done(done), .err(err), .batch_cnt(batch_cnt),
    .fc_in_vld(fc_in_vld), .fc_in_dat(fc_in_dat), .fc_out_vld(fc_out_vld), .fc_out_dat(fc_out_dat),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  fc_batch_sequencer #(.DIM_INPUT(4), .DIM_OUTPUT(5), .TIMEOUT_CYC(64)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .batch_num(bn5), .abort(1'b0),
    .busy(busy5), .done(done5), .err(err5), .batch_cnt(bc5),
    .fc_in_vld(in_vld5), .fc_in_dat(in_dat5), .fc_out_vld(fc_out_vld5), .fc_out_dat(fc_out_dat5),
    .mem_addr(addr5), .mem_en(en5), .mem_we(we5), .mem_din(din5), .mem_dout(dout5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pop_in();
    return in_q.size() != 0 ? 64'(in_q.pop_front()) : 64'hx;
  endfunction

  function automatic logic [63:0] pop_rd();
    return rd_q.size() != 0 ? 64'(rd_q.pop_front()) : 64'hx;
  endfunction

  function automatic logic [63:0] pop_wr();
    return wr_q.size() != 0 ? 64'(wr_q.pop_front()) : 64'hx;
  endfunction

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models with 1-cycle read latency, reloaded with the input pattern during reset
  always @(posedge clk)
    if (!rst_n) begin
      mem_dout <= '0;
      dout5 <= '0;
      for (int k = 0; k < 4096; k++) begin
        mem[k] <= {16'(2*k+1), 16'(2*k)};
        mem5[k] <= 32'hFFFF_FFFF;
      end
    end else begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_din;
      if (mem_en && !mem_we) mem_dout <= mem[mem_addr];
      if (en5 && we5) mem5[addr5] <= din5;
      if (en5 && !we5) dout5 <= mem5[addr5];
    end

  // scoreboard monitors: inputs, reads (address and spacing), writes, done pulses
  always @(negedge clk) begin
    if (fc_in_vld) begin
      chk("in_dat", 64'(fc_in_dat), pop_in());
      last_in <= cyc;
    end
    if (!busy) rd_k <= 0;
    if (mem_en && !mem_we) begin
      chk("rd_addr", 64'(mem_addr), pop_rd());
      if (rd_k != 0) chk("rd_gap", 64'(cyc - last_rd), 64'd2);
      last_rd <= cyc;
      rd_k <= rd_k == DI/2 - 1 ? 0 : rd_k + 1;
    end
    if (mem_en && mem_we) chk("wr", 64'({mem_addr, mem_din}), pop_wr());
    if (done) n_done <= n_done + 1;
  end

  // core model: answers each full input vector 5 cycles later and predicts the stored words
  initial begin : core
    int n_in, bidx;
    bit gl_done;
    n_in = 0; bidx = 0; gl_done = 0;
    fc_out_vld = 1'b0;
    fc_out_dat = '0;
    forever begin
      @(negedge clk);
      fc_out_vld = 1'b0;
      if (!busy) begin n_in = 0; bidx = 0; gl_done = 0; end
      if (fc_in_vld) n_in++;
      if (glitch && !gl_done && n_in == 20) begin
        fc_out_vld = 1'b1;
        fc_out_dat = '1;
        gl_done = 1;
      end
      if (n_in == DI) begin
        n_in = 0;
        if (resp_en) begin
          repeat (4) @(negedge clk);
          for (int j = 0; j < DO; j++) fc_out_dat[j*8 +: 8] = 8'hA0 + 8'(8*bidx) + 8'(j);
          for (int w = 0; w < DO/2; w++)
            wr_q.push_back({12'hD00 + 12'(4*bidx + w), 8'h0, fc_out_dat[(2*w+1)*8 +: 8], 8'h0, fc_out_dat[2*w*8 +: 8]});
          fc_out_vld = 1'b1;
          bidx++;
        end
      end
    end
  end

  task automatic push_loads(input int nb);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < DI; i++) in_q.push_back(16'(DI*b + i));
      for (int k = 0; k < DI/2; k++) rd_q.push_back(12'(DI/2*b + k));
    end
  endtask

  task automatic pulse_start(input logic [6:0] bn);
    batch_num = bn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    logic [6:0] prev;
    n = 0;
    prev = batch_cnt;
    bc_seen.delete();
    while (!done && n < lim) begin
      @(negedge clk);
      if (batch_cnt != prev) bc_seen.push_back(batch_cnt);
      prev = batch_cnt;
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_in_q"}, 64'(in_q.size()), 64'd0);
    chk({tag, "_rd_q"}, 64'(rd_q.size()), 64'd0);
    chk({tag, "_wr_q"}, 64'(wr_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, n;
    bit found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; batch_num = '0;
    start5 = 1'b0; bn5 = '0; fc_out_vld5 = 1'b0; fc_out_dat5 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_err_cnt", 64'({err, batch_cnt}), 64'd0);
    chk("rst_fc_in", 64'({fc_in_vld, fc_in_dat}), 64'd0);
    chk("rst_mem", 64'({mem_en, mem_we, mem_addr, mem_din}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: one batch, inputs 0..95, 48 reads two cycles apart
    push_loads(1);
    pulse_start(7'd1);
    wait_done("t1_done", 2000);
    chk("t1_cnt", 64'(batch_cnt), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    @(negedge clk);
    chk("t1_idle", 64'({busy, done}), 64'd0);
    chk_empty("t1");

    // T2: three batches, start while busy ignored, single done pulse
    repeat (2) @(negedge clk);
    push_loads(3);
    d0 = n_done;
    pulse_start(7'd3);
    repeat (50) @(negedge clk);
    pulse_start(7'd5);
    wait_done("t2_done", 3000);
    chk("t2_seen_n", 64'(bc_seen.size()), 64'd3);
    for (int i = 0; i < 3 && bc_seen.size() != 0; i++) chk("t2_seen", 64'(bc_seen.pop_front()), 64'(i + 1));
    repeat (3) @(negedge clk);
    chk("t2_pulses", 64'(n_done - d0), 64'd1);
    chk("t2_cnt", 64'(batch_cnt), 64'd3);
    chk("t2_w0", 64'(mem[12'hD00]), 64'h00A1_00A0);
    chk("t2_w11", 64'(mem[12'hD0B]), 64'h00B7_00B6);
    chk_empty("t2");

    // T3: zero batches -> immediate done, no traffic
    d0 = n_done;
    pulse_start(7'd0);
    chk("t3_done", 64'({busy, done}), 64'b11);
    @(negedge clk);
    chk("t3_idle", 64'({busy, done}), 64'd0);
    chk("t3_pulses", 64'(n_done - d0), 64'd1);
    chk("t3_cnt", 64'(batch_cnt), 64'd0);

    // T4: core silent -> timeout
    resp_en = 1'b0;
    push_loads(1);
    pulse_start(7'd1);
    wait_done("t4_done", 5000);
    chk("t4_latency", 64'(cyc - last_in), 64'(TO + 1));
    chk("t4_err", 64'(err), 64'b01);
    chk("t4_cnt", 64'(batch_cnt), 64'd0);
    resp_en = 1'b1;
    repeat (2) @(negedge clk);

    // T5: abort at element 40 of batch 2, then restart
    push_loads(2);
    pulse_start(7'd3);
    n = 0;
    found = 0;
    while (!found && n < 1000) begin
      @(negedge clk);
      found = batch_cnt == 7'd1 && fc_in_vld && fc_in_dat == 16'(DI + 40);
      n++;
    end
    chk("t5_reach", 64'(found), 64'd1);
    d0 = n_done;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort", 64'({busy, fc_in_vld, mem_en, mem_we}), 64'd0);
    repeat (5) @(negedge clk);
    chk("t5_no_done", 64'(n_done - d0), 64'd0);
    chk("t5_cnt", 64'(batch_cnt), 64'd1);
    chk("t5_err_clr", 64'(err), 64'd0);
    in_q.delete();
    rd_q.delete();
    push_loads(1);
    pulse_start(7'd1);
    wait_done("t5_restart", 2000);
    chk("t5_cnt2", 64'(batch_cnt), 64'd1);
    @(negedge clk);
    chk_empty("t5");

    // T6: stray result during LOAD flags err[1] without disturbing the run
    repeat (2) @(negedge clk);
    glitch = 1'b1;
    push_loads(1);
    pulse_start(7'd1);
    wait_done("t6_done", 2000);
    glitch = 1'b0;
    chk("t6_err", 64'(err), 64'b10);
    chk("t6_cnt", 64'(batch_cnt), 64'd1);
    @(negedge clk);
    chk_empty("t6");

    // T6b: five outputs pack into three words, last upper slot zero
    bn5 = 7'd1;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    n = 0;
    while (!in_vld5 && n < 100) begin @(negedge clk); n++; end
    while (in_vld5 && n < 200) begin @(negedge clk); n++; end
    chk("t6b_in_end", 64'(in_vld5), 64'd0);
    fc_out_dat5 = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
    fc_out_vld5 = 1'b1;
    @(negedge clk);
    fc_out_vld5 = 1'b0;
    n = 0;
    while (!done5 && n < 100) begin @(negedge clk); n++; end
    chk("t6b_done", 64'(done5), 64'd1);
    chk("t6b_w0", 64'(mem5[12'hD00]), 64'h0012_0011);
    chk("t6b_w1", 64'(mem5[12'hD01]), 64'h0014_0013);
    chk("t6b_w2", 64'(mem5[12'hD02]), 64'h0000_0015);
    chk("t6b_w3", 64'(mem5[12'hD03]), 64'hFFFF_FFFF);
    chk("t6b_stat", 64'({err5, bc5}), 64'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
